// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states and default bus geometry.
// Imported by the master bridge, the slave memory and the arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    localparam int unsigned APB_ADDR_W      = 32;
    localparam int unsigned APB_DATA_W      = 32;
    localparam int unsigned APB_TIMEOUT_DEF = 16;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: one valid/ready request becomes one APB setup/access
// transfer, and the result comes back on a valid/ready response channel.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic              pclk,
    input  logic              preset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    apb_state_e       state;
    logic [CNT_W-1:0] wait_cnt;

    assign req_ready = (state == IDLE);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        pwrite  <= req_write;
                        paddr   <= req_addr;
                        pwdata  <= req_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        // Only clean read data is forwarded; error/write responses read as zero.
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
